// File: rtl/vector_alu_sequencer.sv
// rtl/vector_alu_sequencer.sv - sequences one vector operation lane by lane through a shared scalar ALU
//
// Purpose:
//   Accepts one vector operation (opcode plus two operand vectors) in IDLE.
//   In RUN it feeds one lane per cycle to an external combinational ALU and
//   captures that lane's result and flags. It then pulses done for one cycle
//   in DONE. Illegal opcodes skip RUN and finish with err=1.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, op         operation request and 3-bit opcode
//   vec_a, vec_b      operand vectors, lane i = [i*dataSize +: dataSize]
//   alu_result        ALU result for the current alu_* drive
//   alu_neg, alu_zero ALU flags for the current alu_* drive
//   alu_op            opcode to the ALU, 0 outside RUN
//   alu_a, alu_b      lane operands to the ALU, 0 outside RUN
//   ready, busy, done state indications (IDLE / RUN / one-cycle DONE)
//   err               illegal-opcode flag, valid with done
//   vec_result        captured per-lane results
//   neg_mask          captured per-lane neg flags
//   zero_mask         captured per-lane zero flags
module vector_alu_sequencer #(
  parameter int dataSize = 8,
  parameter int lanes    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [2:0]                  op,
  input  logic [lanes*dataSize-1:0]   vec_a,
  input  logic [lanes*dataSize-1:0]   vec_b,
  input  logic [dataSize-1:0]         alu_result,
  input  logic                        alu_neg,
  input  logic                        alu_zero,
  output logic [2:0]                  alu_op,
  output logic [dataSize-1:0]         alu_a,
  output logic [dataSize-1:0]         alu_b,
  output logic                        ready,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [lanes*dataSize-1:0]   vec_result,
  output logic [lanes-1:0]            neg_mask,
  output logic [lanes-1:0]            zero_mask
);

  localparam int CW = ($clog2(lanes) < 1) ? 1 : $clog2(lanes);
  localparam logic [CW-1:0] LAST_LANE = CW'(lanes - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [2:0]                  op_q, op_d;
  logic [lanes*dataSize-1:0]   a_q, a_d;
  logic [lanes*dataSize-1:0]   b_q, b_d;
  logic [lanes*dataSize-1:0]   vec_result_q, vec_result_d;
  logic [lanes-1:0]            neg_mask_q, neg_mask_d;
  logic [lanes-1:0]            zero_mask_q, zero_mask_d;
  logic                        err_q, err_d;
  logic                        ready_q, ready_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [2:0]                  alu_op_q, alu_op_d;
  logic [dataSize-1:0]         alu_a_q, alu_a_d;
  logic [dataSize-1:0]         alu_b_q, alu_b_d;
  logic                        op_legal;

  assign op_legal = (op != 3'b000) && (op != 3'b111);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    vec_result_d = vec_result_q;
    neg_mask_d   = neg_mask_q;
    zero_mask_d  = zero_mask_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d         = op;
          a_d          = vec_a;
          b_d          = vec_b;
          cnt_d        = '0;
          vec_result_d = '0;
          neg_mask_d   = '0;
          zero_mask_d  = '0;
          err_d        = !op_legal;
          state_d      = op_legal ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        vec_result_d[cnt_q*dataSize +: dataSize] = alu_result;
        neg_mask_d[cnt_q]  = alu_neg;
        zero_mask_d[cnt_q] = alu_zero;
        // Counter parks on the last lane rather than wrapping.
        if (cnt_q == LAST_LANE) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so the ALU sees the lane
    // selected by cnt for the whole RUN cycle in which it is captured.
    ready_d  = (state_d == S_IDLE);
    busy_d   = (state_d == S_RUN);
    done_d   = (state_d == S_DONE);
    alu_op_d = '0;
    alu_a_d  = '0;
    alu_b_d  = '0;
    if (state_d == S_RUN) begin
      alu_op_d = op_d;
      alu_a_d  = a_d[cnt_d*dataSize +: dataSize];
      alu_b_d  = b_d[cnt_d*dataSize +: dataSize];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      vec_result_q <= '0;
      neg_mask_q   <= '0;
      zero_mask_q  <= '0;
      err_q        <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      vec_result_q <= vec_result_d;
      neg_mask_q   <= neg_mask_d;
      zero_mask_q  <= zero_mask_d;
      err_q        <= err_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
    end
  end

  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign ready      = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign vec_result = vec_result_q;
  assign neg_mask   = neg_mask_q;
  assign zero_mask  = zero_mask_q;

endmodule

// File: doc/vector_alu_sequencer.md
VECTOR_ALU_SEQUENCER -- requirements
Module: vector_alu_sequencer

Interface
REQ-001 SHALL have parameter dataSize, default 8, lane element width in bits.
REQ-002 SHALL have parameter lanes, default 4, number of vector elements (2..16).
REQ-003 SHALL have one clock and a synchronous, active-high reset; all state SHALL change on the rising clk edge only.
REQ-004 clk  input  1  clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  request to execute one vector operation.
REQ-007 op  input  3  ALU opcode: 001 xor, 010 add, 011 sub, 100 mul, 101 shr, 110 shl; 000/111 illegal.
REQ-008 vec_a, vec_b  input  lanes*dataSize each  operand vectors; lane i = bits [i*dataSize +: dataSize].
REQ-009 alu_result  input  dataSize  result from the shared ALU, combinational on the alu_* outputs.
REQ-010 alu_neg, alu_zero  input  1 each  ALU neg and zero flags for the current alu_* drive.
REQ-011 alu_op  output  3  opcode driven to the ALU operation_select.
REQ-012 alu_a, alu_b  output  dataSize each  operands driven to the ALU.
REQ-013 ready  output  1  high only in IDLE.
REQ-014 busy  output  1  high in RUN.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 err  output  1  valid with done; high when op was illegal.
REQ-017 vec_result  output  lanes*dataSize  per-lane results, lane order as vec_a.
REQ-018 neg_mask, zero_mask  output  lanes each  per-lane alu_neg / alu_zero captures.

Function
REQ-019 FSM states SHALL be IDLE, RUN and DONE.
REQ-020 IDLE: start=1 SHALL be accepted; op, vec_a and vec_b SHALL be latched, the lane counter cleared, vec_result/neg_mask/zero_mask cleared, and the next state SHALL be RUN (legal op) or DONE with err=1 (illegal op).
REQ-021 start while in RUN or DONE SHALL be ignored with no side effect; inputs changing after acceptance SHALL not affect the operation.
REQ-022 RUN: each cycle SHALL drive alu_op=latched op and alu_a/alu_b=latched lane[cnt] of A/B, and capture alu_result, alu_neg, alu_zero into lane cnt at the clock edge.
REQ-023 Lanes SHALL be processed in order 0..lanes-1, one per cycle; after lane lanes-1 is captured the next state SHALL be DONE.
REQ-024 Latency: start accepted at edge T; lane i captured at edge T+1+i; done=1 during the cycle after edge T+lanes; ready returns the cycle after that.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; vec_result, masks and err SHALL hold until the next accepted start.
REQ-026 Illegal op: no RUN cycles; done at the cycle after acceptance with err=1, vec_result and masks all zero.
REQ-027 Outside RUN, alu_op, alu_a and alu_b SHALL be driven to 0.
REQ-028 The lane counter SHALL be ceil(log2(lanes)) bits wide (minimum 1) and SHALL not wrap inside an operation.
REQ-029 Arithmetic is the ALU's: results are taken verbatim (dataSize bits, truncated), with no sign or overflow handling in this block.

Reset
REQ-030 While rst=1 at an edge: state=IDLE, counter=0, ready=1, busy=0, done=0, err=0, vec_result=0, neg_mask=0, zero_mask=0, alu_*=0.
REQ-031 rst asserted in RUN or DONE SHALL abort the operation with no done pulse; start in the same cycle as rst SHALL be ignored.

Verification (dataSize=8, lanes=4; vectors written lane3..lane0)
REQ-032 add: op=010, A={4,3,2,1}, B={1,1,1,1}, start -> busy for 4 cycles, one done pulse 5 cycles after acceptance, vec_result={5,4,3,2}, err=0, masks=0.
REQ-033 sub flags: op=011, A={0,3,5,1}, B={0,2,5,3} -> vec_result={0,1,0,0xFE}, zero_mask=1010b, neg_mask=0001b.
REQ-034 mul/shift: op=100, A={3,3,3,3}, B={2,2,2,2} -> {6,6,6,6}; then op=110 with B={2,2,2,2} -> {12,12,12,12}; then op=101 with B={1,1,1,1} -> {1,1,1,1}.
REQ-035 illegal op=111 -> done one cycle after acceptance, err=1, vec_result=0, alu_op remains 000.
REQ-036 start pulsed again mid-RUN with different operands -> ignored, first result unchanged; rst asserted on lane 2 -> no done, all outputs at reset values next cycle, ready=1.
